// File: rtl/jtbubl_sndcomm_main.sv
// Main-CPU end of the main<->sound mailbox: command latch/strobe, reply capture, sound reset, IRQ.
// Define JTBUBL_SNDCOMM_FIFO_EN to turn the single reply register into a 2**FIFO_AW byte FIFO.
module jtbubl_sndcomm_main #(
    parameter int RST_LEN = 16,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] snd_latch,
    output logic       snd_stb,
    input  logic [7:0] main_latch,
    input  logic       main_stb,
    input  logic       snd_flag,
    output logic       main_flag,
    output logic       snd_rstn,
    output logic       int_n
);
    localparam int CW = (RST_LEN > 2) ? $clog2(RST_LEN) : 1;
    localparam logic [CW-1:0] RST_LOAD = CW'(RST_LEN - 1);

    logic          w_wr_cond, w_rd_cond, w_wr_start, w_rd_start, w_rd_end;
    logic          w_pop, w_ovr_clr, w_cap, w_main_flag;
    logic [7:0]    w_head;
    logic          r_wr_act, r_rd_act, r_stb_prev;
    logic [1:0]    r_rd_addr;
    logic [7:0]    r_snd_latch;
    logic          r_snd_stb, r_int_en, r_snd_rstn, r_rel_req, r_int_n, r_ovr;
    logic [CW-1:0] r_rst_cnt;

    // Each access fires its side effects once: start on the rising condition, end on the falling one.
    assign w_wr_cond  = cs & ~wr_n;
    assign w_rd_cond  = cs & ~rd_n;
    assign w_wr_start = w_wr_cond & ~r_wr_act;
    assign w_rd_start = w_rd_cond & ~r_rd_act;
    assign w_rd_end   = ~w_rd_cond & r_rd_act;
    assign w_pop      = w_rd_end & (r_rd_addr == 2'd0);
    assign w_ovr_clr  = w_rd_end & (r_rd_addr == 2'd1);
    assign w_cap      = main_stb & ~r_stb_prev & r_snd_rstn;

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_act   <= 1'b0;
            r_rd_act   <= 1'b0;
            r_rd_addr  <= 2'd0;
            r_stb_prev <= 1'b0;
        end else begin
            r_wr_act   <= w_wr_cond;
            r_rd_act   <= w_rd_cond;
            r_stb_prev <= main_stb;
            if (w_rd_start) r_rd_addr <= addr;
        end
    end

    // Command latch, interrupt enable and the sound CPU reset sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snd_latch <= 8'h00;
            r_snd_stb   <= 1'b0;
            r_int_en    <= 1'b0;
            r_snd_rstn  <= 1'b0;
            r_rel_req   <= 1'b1;
            r_rst_cnt   <= RST_LOAD;
        end else begin
            r_snd_stb  <= 1'b0;
            r_snd_rstn <= r_rel_req & (r_rst_cnt == '0);
            if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - 1'b1;
            if (w_wr_start) begin
                case (addr)
                    2'd0: begin
                        r_snd_latch <= din;
                        r_snd_stb   <= r_snd_rstn;
                    end
                    2'd1: begin
                        if (!din[0]) begin
                            r_snd_rstn <= 1'b0;
                            r_rst_cnt  <= RST_LOAD;
                            r_rel_req  <= 1'b0;
                        end else begin
                            r_rel_req  <= 1'b1;
                        end
                    end
                    2'd2:    r_int_en <= din[0];
                    default: ;
                endcase
            end
        end
    end

`ifdef JTBUBL_SNDCOMM_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_pop, w_do_push, w_full;

    assign w_full      = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_do_pop    = w_pop & (r_count != '0);
    assign w_do_push   = w_cap & (~w_full | w_do_pop);
    assign w_main_flag = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; only pointers and count are cleared, stale bytes are never visible as valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= main_latch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_ovr_clr) r_ovr <= 1'b0;
            if (w_cap && !w_do_push) r_ovr <= 1'b1;
            if (!r_snd_rstn) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
                else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
            end
        end
    end
`else
    logic [7:0] r_reply;
    logic       r_flag;

    assign w_main_flag = r_flag;
    assign w_head      = r_reply;

    // A capture on the same edge as a pop wins and is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reply <= 8'h00;
            r_flag  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_ovr_clr) r_ovr <= 1'b0;
            if (!r_snd_rstn) begin
                r_flag <= 1'b0;
            end else if (w_cap) begin
                r_reply <= main_latch;
                r_flag  <= 1'b1;
                if (r_flag && !w_pop) r_ovr <= 1'b1;
            end else if (w_pop) begin
                r_flag <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_int_n <= 1'b1;
        else     r_int_n <= ~(r_int_en & w_main_flag);
    end

    // NOTE: the read mux assigns a default first so no latch is inferred for unselected cases.
    always_comb begin
        dout = 8'hff;
        if (cs) begin
            case (addr)
                2'd0:    dout = w_head;
                2'd1:    dout = {4'hf, r_ovr, r_snd_rstn, w_main_flag, snd_flag};
                2'd2:    dout = {7'h7f, r_int_en};
                default: dout = 8'hff;
            endcase
        end
    end

    assign snd_latch = r_snd_latch;
    assign snd_stb   = r_snd_stb;
    assign main_flag = w_main_flag;
    assign snd_rstn  = r_snd_rstn;
    assign int_n     = r_int_n;
endmodule
